// File: rtl/hazard_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared definitions for the pipeline hazard / stall controller of the 5-stage
// 16-bit core: FSM state encoding, register-file constants, the HLT opcode,
// grouped enable/flush types and the load-use hazard test.
// -----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_e;

  localparam logic [3:0] REG_ZERO = 4'd0;

  // Opcode of HLT; the decoder that produces memwb_halt compares against it.
  localparam logic [3:0] OP_HLT = 4'hF;

  // Width of the memory-wait counter; covers the full MEM_TIMEOUT range.
  localparam int WAIT_W = 16;

  // Pipeline-register write enables, fetch side first.
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } we_t;

  // Bubble loads for the registers that can be squashed.
  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
  } flush_t;

  function automatic logic is_hlt_op(input logic [3:0] opcode);
    return opcode == OP_HLT;
  endfunction

  // A load in ID_EX whose destination is read by the instruction in IF_ID.
  // R0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic ld_use_hazard(
    input logic       mem_read,
    input logic [3:0] rd,
    input logic [3:0] rs1,
    input logic       rs1_used,
    input logic [3:0] rs2,
    input logic       rs2_used
  );
    return mem_read && (rd != REG_ZERO) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Pipeline-control bundle between the hazard/stall controller (master, drives
// the write enables) and the pipeline datapath (slave, supplies hazard inputs).
//   Hazard inputs : id_rs1/2, id_rs1/2_used, idex_mem_read, idex_rd,
//                   exmem_branch_taken, mem_req, mem_ready, memwb_halt
//   Controls      : pc/ifid/idex/exmem/memwb_we, ifid/idex/exmem_flush
//   Status        : halted, mem_timeout, stall_count, flush_count
// -----------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);

  logic [3:0]       id_rs1;
  logic [3:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             idex_mem_read;
  logic [3:0]       idex_rd;
  logic             exmem_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             memwb_halt;

  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             exmem_we;
  logic             memwb_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, idex_mem_read, idex_rd,
           exmem_branch_taken, mem_req, mem_ready, memwb_halt,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush,
           halted, mem_timeout, stall_count, flush_count
  );

  modport slave (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, idex_mem_read, idex_rd,
           exmem_branch_taken, mem_req, mem_ready, memwb_halt,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush,
           halted, mem_timeout, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// CNT_W-bit up counter that sticks at all-ones instead of wrapping.
//   clk, rst  : clock, asynchronous active-high reset (clears to zero)
//   i_inc     : count this cycle
//   o_count   : current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples values from before the edge regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Central pipeline control: each cycle decides whether PC, IF_ID, ID_EX,
// EX_MEM and MEM_WB load, hold or take a bubble. Handles load-use stalls,
// taken-branch flushes, memory waits with a timeout, and HLT retirement.
//   clk, rst : clock, asynchronous active-high reset
//   ctrl     : hazard_stall_ctrl_if master (hazard inputs in, write enables,
//              flushes, halted, mem_timeout and the two counters out)
// Enables/flushes are combinational from the registered state and the inputs.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.master ctrl
);

  state_e            r_state;
  state_e            w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_timeout;
  logic              w_timeout_nxt;
  we_t               w_we;
  flush_t            w_flush;
  logic              w_stall_inc;
  logic              w_flush_inc;
  logic              w_ld_use;

  assign w_ld_use = ld_use_hazard(ctrl.idex_mem_read, ctrl.idex_rd,
                                  ctrl.id_rs1, ctrl.id_rs1_used,
                                  ctrl.id_rs2, ctrl.id_rs2_used);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_timeout;
    w_we           = '0;
    w_flush        = '0;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (ctrl.memwb_halt) begin
          // HLT retires: nothing moves, the core stops at the next edge.
          w_next_state = ST_HALTED;
        end else if (ctrl.mem_req && !ctrl.mem_ready) begin
          // First frozen cycle of a memory wait; counted as a stall cycle and
          // as the first cycle of the wait.
          w_next_state   = ST_MEM_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
          w_stall_inc    = 1'b1;
        end else if (ctrl.exmem_branch_taken) begin
          // Squash the three younger instructions; the load-use stall, if
          // any, belonged to a wrong-path instruction.
          w_we        = '1;
          w_flush     = '1;
          w_flush_inc = 1'b1;
        end else if (w_ld_use) begin
          // Hold PC and IF_ID, push a bubble into ID_EX. The bubble clears
          // idex_mem_read, so the stall lasts exactly one cycle.
          w_we         = '{pc: 1'b0, ifid: 1'b0, idex: 1'b1, exmem: 1'b1, memwb: 1'b1};
          w_flush.idex = 1'b1;
          w_stall_inc  = 1'b1;
        end else begin
          w_we = '1;
        end
      end

      ST_MEM_WAIT: begin
        w_stall_inc = 1'b1;
        if (ctrl.mem_ready) begin
          // Enables stay low this cycle; the pipeline advances next cycle.
          w_next_state   = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT)) begin
          w_timeout_nxt  = 1'b1;
          w_next_state   = ST_HALTED;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end

      ST_HALTED: begin
        // Only reset leaves this state.
      end

      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    // Nothing in the pipeline may load while reset is held.
    if (rst) begin
      w_we    = '0;
      w_flush = '0;
    end
  end

  assign ctrl.pc_we       = w_we.pc;
  assign ctrl.ifid_we     = w_we.ifid;
  assign ctrl.idex_we     = w_we.idex;
  assign ctrl.exmem_we    = w_we.exmem;
  assign ctrl.memwb_we    = w_we.memwb;
  assign ctrl.ifid_flush  = w_flush.ifid;
  assign ctrl.idex_flush  = w_flush.idex;
  assign ctrl.exmem_flush = w_flush.exmem;
  assign ctrl.halted      = (r_state == ST_HALTED);
  assign ctrl.mem_timeout = r_timeout;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_stall_inc),
    .o_count (ctrl.stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_flush_inc),
    .o_count (ctrl.flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Self-checking bench. The main instance (MEM_TIMEOUT=8, 3-bit counters so
// saturation is reachable) is compared every cycle against a behavioural
// model; a second instance (MEM_TIMEOUT=4) exercises the timeout path.
// Directed vectors carry hand-computed literal expectations as well.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int CNT_W   = 3;
  localparam int TO_MAIN = 8;
  localparam int TO_SHORT = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus    ();
  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus_to ();

  hazard_stall_ctrl #(.MEM_TIMEOUT(TO_MAIN), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  hazard_stall_ctrl #(.MEM_TIMEOUT(TO_SHORT), .CNT_W(CNT_W)) dut_to (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus_to)
  );

  logic [4:0] we_m, we_t;
  logic [2:0] fl_m, fl_t;
  assign we_m = {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we};
  assign fl_m = {bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
  assign we_t = {bus_to.pc_we, bus_to.ifid_we, bus_to.idex_we, bus_to.exmem_we, bus_to.memwb_we};
  assign fl_t = {bus_to.ifid_flush, bus_to.idex_flush, bus_to.exmem_flush};

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model of the main instance. It tracks: whether the core has
  // stopped, the sticky timeout, how many frozen cycles a memory wait has run,
  // and the two event totals (clipped at the counter ceiling).
  // ---------------------------------------------------------------------------
  bit m_halted  = 1'b0;
  bit m_timeout = 1'b0;
  int m_frozen  = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  always @(negedge clk) begin : compare
    logic [4:0]  e_we;
    logic [2:0]  e_fl;
    logic [15:0] reads;
    logic        hz;
    bit          inc_s, inc_f, n_halted, n_timeout;
    int          n_frozen;

    e_we  = '0;
    e_fl  = '0;
    inc_s = 1'b0;
    inc_f = 1'b0;

    // Set of registers the ID instruction reads; R0 is excluded explicitly.
    reads = '0;
    if (bus.id_rs1_used) reads[bus.id_rs1] = 1'b1;
    if (bus.id_rs2_used) reads[bus.id_rs2] = 1'b1;
    reads[0] = 1'b0;
    hz = bus.idex_mem_read && reads[bus.idex_rd];

    if (rst) begin
      m_halted  = 1'b0;
      m_timeout = 1'b0;
      m_frozen  = 0;
      m_stalls  = 0;
      m_flushes = 0;
    end

    n_halted  = m_halted;
    n_timeout = m_timeout;
    n_frozen  = m_frozen;

    if (rst || m_halted) begin
      // everything held
    end else if (m_frozen > 0) begin
      inc_s = 1'b1;
      if (bus.mem_ready) n_frozen = 0;
      else if (m_frozen == TO_MAIN) begin
        n_timeout = 1'b1;
        n_halted  = 1'b1;
        n_frozen  = 0;
      end else n_frozen = m_frozen + 1;
    end else if (bus.memwb_halt) begin
      n_halted = 1'b1;
    end else if (bus.mem_req && !bus.mem_ready) begin
      inc_s    = 1'b1;
      n_frozen = 1;
    end else if (bus.exmem_branch_taken) begin
      e_we  = 5'b11111;
      e_fl  = 3'b111;
      inc_f = 1'b1;
    end else if (hz) begin
      e_we  = 5'b00111;
      e_fl  = 3'b010;
      inc_s = 1'b1;
    end else begin
      e_we = 5'b11111;
    end

    check("model_we",      32'(we_m),            32'(e_we));
    check("model_flush",   32'(fl_m),            32'(e_fl));
    check("model_halted",  32'(bus.halted),      32'(m_halted));
    check("model_timeout", 32'(bus.mem_timeout), 32'(m_timeout));
    check("model_stalls",  32'(bus.stall_count), 32'(m_stalls));
    check("model_flushes", 32'(bus.flush_count), 32'(m_flushes));

    if (!rst) begin
      m_halted  = n_halted;
      m_timeout = n_timeout;
      m_frozen  = n_frozen;
      if (inc_s && m_stalls < SAT)  m_stalls++;
      if (inc_f && m_flushes < SAT) m_flushes++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the rising edge, literal checks
  // are made 1 ns after the falling edge.
  // ---------------------------------------------------------------------------
  task automatic set_in(input logic [3:0] rs1, input logic u1,
                        input logic [3:0] rs2, input logic u2,
                        input logic mr, input logic [3:0] rd, input logic br,
                        input logic req, input logic rdy, input logic hlt);
    bus.id_rs1             = rs1;
    bus.id_rs1_used        = u1;
    bus.id_rs2             = rs2;
    bus.id_rs2_used        = u2;
    bus.idex_mem_read      = mr;
    bus.idex_rd            = rd;
    bus.exmem_branch_taken = br;
    bus.mem_req            = req;
    bus.mem_ready          = rdy;
    bus.memwb_halt         = hlt;
  endtask

  task automatic idle_to();
    bus_to.id_rs1             = 4'd0;
    bus_to.id_rs1_used        = 1'b0;
    bus_to.id_rs2             = 4'd0;
    bus_to.id_rs2_used        = 1'b0;
    bus_to.idex_mem_read      = 1'b0;
    bus_to.idex_rd            = 4'd0;
    bus_to.exmem_branch_taken = 1'b0;
    bus_to.mem_req            = 1'b0;
    bus_to.mem_ready          = 1'b0;
    bus_to.memwb_halt         = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_to();
    settle();
    settle();
    check("rst_we",      32'(we_m), 32'h00);
    check("rst_flush",   32'(fl_m), 32'h0);
    check("rst_halted",  32'(bus.halted), 32'h0);
    check("rst_stalls",  32'(bus.stall_count), 32'h0);
    check("rst_to_we",   32'(we_t), 32'h00);
    rst = 1'b0;

    // Idle: everything advances.
    next_cycle(); settle();
    check("idle_we", 32'(we_m), 32'h1f);

    // Load-use on rs1 = r3: one bubble.
    next_cycle(); set_in(4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("lduse_we",    32'(we_m), 32'h07);
    check("lduse_flush", 32'(fl_m), 32'h2);
    next_cycle(); set_in(4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("lduse_after_we",     32'(we_m), 32'h1f);
    check("lduse_after_stalls", 32'(bus.stall_count), 32'd1);

    // No false hazards: R0, and an rs2 match that is not read.
    next_cycle(); set_in(4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("r0_we", 32'(we_m), 32'h1f);
    next_cycle(); set_in(4'd2, 1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("rs2_unused_we", 32'(we_m), 32'h1f);
    next_cycle(); set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("no_false_stalls", 32'(bus.stall_count), 32'd1);

    // Branch together with a load-use on rs2: the flush wins.
    next_cycle(); set_in(4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0); settle();
    check("br_ld_we",    32'(we_m), 32'h1f);
    check("br_ld_flush", 32'(fl_m), 32'h7);
    next_cycle(); set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("br_ld_flushes", 32'(bus.flush_count), 32'd1);
    check("br_ld_stalls",  32'(bus.stall_count), 32'd1);

    // Memory wait: 5 cycles not ready then ready, with a branch held frozen.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, (i == 5), 1'b0);
      settle();
      check("memwait_we",    32'(we_m), 32'h00);
      check("memwait_flush", 32'(fl_m), 32'h0);
    end
    next_cycle(); set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); settle();
    check("memwait_br_we",    32'(we_m), 32'h1f);
    check("memwait_br_flush", 32'(fl_m), 32'h7);
    check("memwait_stalls",   32'(bus.stall_count), 32'd7);
    next_cycle(); set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("memwait_flushes", 32'(bus.flush_count), 32'd2);

    // Stall counter is at its ceiling; one more load-use must not wrap it.
    next_cycle(); set_in(4'd9, 1'b1, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("sat_lduse_we", 32'(we_m), 32'h07);
    next_cycle(); set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0); settle();
    check("sat_stalls", 32'(bus.stall_count), 32'd7);

    // Access that completes in the same cycle costs nothing.
    next_cycle(); set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0); settle();
    check("req_ready_we", 32'(we_m), 32'h1f);

    // HLT retires, then the core stays stopped whatever the inputs do.
    next_cycle(); set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); settle();
    check("hlt_we",     32'(we_m), 32'h00);
    check("hlt_halted", 32'(bus.halted), 32'h0);
    next_cycle(); set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); settle();
    check("halted_we",    32'(we_m), 32'h00);
    check("halted_flush", 32'(fl_m), 32'h0);
    check("halted_flag",  32'(bus.halted), 32'h1);
    next_cycle(); set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0); settle();
    check("halted_stays", 32'(bus.halted), 32'h1);

    // Reset out of HALTED.
    next_cycle(); rst = 1'b1; set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    check("unhalt_halted", 32'(bus.halted), 32'h0);
    rst = 1'b0;

    // Async reset in the middle of a memory wait.
    next_cycle(); set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0); settle();
    next_cycle(); settle();
    next_cycle();
    check("midwait_stalls", 32'(bus.stall_count), 32'd2);
    #3 rst = 1'b1;
    #1;
    check("midrst_we",      32'(we_m), 32'h00);
    check("midrst_stalls",  32'(bus.stall_count), 32'd0);
    check("midrst_flushes", 32'(bus.flush_count), 32'd0);
    check("midrst_halted",  32'(bus.halted), 32'h0);
    settle();
    rst = 1'b0;
    set_in(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle(); settle();
    check("after_midrst_we", 32'(we_m), 32'h1f);

    // Timeout on the short-timeout instance: memory never answers.
    next_cycle(); bus_to.mem_req = 1'b1; bus_to.mem_ready = 1'b0; settle();
    check("to_freeze_we", 32'(we_t), 32'h00);
    for (int i = 1; i <= TO_SHORT; i++) begin
      next_cycle(); settle();
      check("to_wait_we",      32'(we_t), 32'h00);
      check("to_wait_timeout", 32'(bus_to.mem_timeout), 32'h0);
      check("to_wait_halted",  32'(bus_to.halted), 32'h0);
    end
    check("to_wait_stalls", 32'(bus_to.stall_count), 32'd4);
    next_cycle(); settle();
    check("to_timeout", 32'(bus_to.mem_timeout), 32'h1);
    check("to_halted",  32'(bus_to.halted), 32'h1);
    check("to_stalls",  32'(bus_to.stall_count), 32'd5);
    next_cycle(); bus_to.mem_ready = 1'b1; bus_to.mem_req = 1'b0; settle();
    check("to_sticky_timeout", 32'(bus_to.mem_timeout), 32'h1);
    check("to_sticky_halted",  32'(bus_to.halted), 32'h1);
    check("to_sticky_we",      32'(we_t), 32'h00);
    check("to_sticky_stalls",  32'(bus_to.stall_count), 32'd5);

    next_cycle(); rst = 1'b1; idle_to(); settle();
    check("to_rst_timeout", 32'(bus_to.mem_timeout), 32'h0);
    check("to_rst_halted",  32'(bus_to.halted), 32'h0);
    check("to_rst_stalls",  32'(bus_to.stall_count), 32'd0);
    rst = 1'b0;
    next_cycle(); settle();
    check("to_run_we", 32'(we_t), 32'h1f);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
